// File: rtl/data_ram_arbiter_pkg.sv
// Shared definitions for the data RAM arbiter: RAM bus widths, strobe levels and FSM state encodings.
package data_ram_arbiter_pkg;

  localparam int RAM_DATA_W = 32;
  localparam int RAM_ADDR_W = 32;
  localparam int BE_W       = RAM_DATA_W / 8;

  localparam logic                  ResetEnable = 1'b1;
  localparam logic                  WriteEnable = 1'b1;
  localparam logic [RAM_DATA_W-1:0] ZeroWord    = '0;

  typedef enum logic [2:0] {
    DRA_IDLE,
    DRA_WR,
    DRA_RD_ADDR,
    DRA_RD_DATA,
    DRA_RMW_ADDR,
    DRA_RMW_MERGE,
    DRA_RMW_WR
  } dra_state_t;

endpackage

// File: rtl/data_ram_arbiter_ram_byte_merge.sv
// Combinational byte-lane merge: each byte comes from new_word when its enable is set, else from old_word.
module ram_byte_merge
  import data_ram_arbiter_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  localparam int unsigned LANES = DATA_W / 8;

  always_comb begin
    merged = old_word;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-master data RAM arbiter with read-modify-write sequencing for partial stores; all outputs registered.
// Build option: define DATA_RAM_ARB_FIXED_PRIO_EN for fixed m0 priority instead of round-robin.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              i_Clk,
  input  logic              i_reset,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [BE_W-1:0]   i_m0_be,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [BE_W-1:0]   i_m1_be,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m0_gnt,
  output logic              o_m1_gnt,
  output logic              o_m0_rvalid,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_w_addr,
  output logic [DATA_W-1:0] o_ram_w_data,
  output logic [ADDR_W-1:0] o_ram_r_addr,
  input  logic [DATA_W-1:0] i_ram_r_data
);

  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

  dra_state_t        state, state_n;
  logic              cmd_owner, cmd_owner_n;
  logic [BE_W-1:0]   cmd_be, cmd_be_n;
  logic [ADDR_W-1:0] cmd_addr, cmd_addr_n;
  logic [DATA_W-1:0] cmd_wdata, cmd_wdata_n;

  logic              gnt0_n, gnt1_n, rvalid0_n, rvalid1_n, we_n;
  logic [DATA_W-1:0] rdata0_n, rdata1_n, w_data_n, merged;
  logic [ADDR_W-1:0] w_addr_n, r_addr_n;

  logic              pick_m1, win_we;
  logic [BE_W-1:0]   win_be;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

`ifdef DATA_RAM_ARB_FIXED_PRIO_EN
  assign pick_m1 = i_m1_req & ~i_m0_req;
`else
  logic prefer_m1, prefer_m1_n;
  assign pick_m1 = i_m1_req & (~i_m0_req | prefer_m1);
`endif

  assign win_we    = pick_m1 ? i_m1_we    : i_m0_we;
  assign win_be    = pick_m1 ? i_m1_be    : i_m0_be;
  assign win_addr  = (pick_m1 ? i_m1_addr : i_m0_addr) & AlignMask;
  assign win_wdata = pick_m1 ? i_m1_wdata : i_m0_wdata;

  ram_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word (i_ram_r_data),
    .new_word (cmd_wdata),
    .be       (cmd_be),
    .merged   (merged)
  );

  always_comb begin
    state_n     = state;
    cmd_owner_n = cmd_owner;
    cmd_be_n    = cmd_be;
    cmd_addr_n  = cmd_addr;
    cmd_wdata_n = cmd_wdata;
    gnt0_n      = 1'b0;
    gnt1_n      = 1'b0;
    rvalid0_n   = 1'b0;
    rvalid1_n   = 1'b0;
    we_n        = 1'b0;
    rdata0_n    = o_m0_rdata;
    rdata1_n    = o_m1_rdata;
    w_addr_n    = o_ram_w_addr;
    w_data_n    = o_ram_w_data;
    r_addr_n    = o_ram_r_addr;
`ifndef DATA_RAM_ARB_FIXED_PRIO_EN
    prefer_m1_n = prefer_m1;
`endif
    case (state)
      DRA_IDLE: begin
        if (i_m0_req || i_m1_req) begin
          cmd_owner_n = pick_m1;
          cmd_be_n    = win_be;
          cmd_addr_n  = win_addr;
          cmd_wdata_n = win_wdata;
          gnt0_n      = ~pick_m1;
          gnt1_n      = pick_m1;
`ifndef DATA_RAM_ARB_FIXED_PRIO_EN
          prefer_m1_n = ~pick_m1;
`endif
          // Zero-enable writes still pass through WR so a held req sees a one-cycle gap
          if (win_we && (win_be == '1 || win_be == '0)) begin
            we_n     = (win_be == '1) ? WriteEnable : 1'b0;
            w_addr_n = (win_be == '1) ? win_addr    : o_ram_w_addr;
            w_data_n = (win_be == '1) ? win_wdata   : o_ram_w_data;
            state_n  = DRA_WR;
          end else begin
            r_addr_n = win_addr;
            state_n  = win_we ? DRA_RMW_ADDR : DRA_RD_ADDR;
          end
        end
      end
      DRA_WR:       state_n = DRA_IDLE;
      DRA_RD_ADDR:  state_n = DRA_RD_DATA;
      DRA_RD_DATA: begin
        rvalid0_n = ~cmd_owner;
        rvalid1_n = cmd_owner;
        if (cmd_owner) rdata1_n = i_ram_r_data;
        else           rdata0_n = i_ram_r_data;
        state_n = DRA_IDLE;
      end
      DRA_RMW_ADDR: state_n = DRA_RMW_MERGE;
      DRA_RMW_MERGE: begin
        we_n     = WriteEnable;
        w_addr_n = cmd_addr;
        w_data_n = merged;
        state_n  = DRA_RMW_WR;
      end
      DRA_RMW_WR:   state_n = DRA_IDLE;
      default:      state_n = DRA_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_reset == ResetEnable) begin
      state        <= DRA_IDLE;
      cmd_owner    <= 1'b0;
      cmd_be       <= '0;
      cmd_addr     <= '0;
      cmd_wdata    <= ZeroWord;
      o_m0_gnt     <= 1'b0;
      o_m1_gnt     <= 1'b0;
      o_m0_rvalid  <= 1'b0;
      o_m1_rvalid  <= 1'b0;
      o_m0_rdata   <= ZeroWord;
      o_m1_rdata   <= ZeroWord;
      o_ram_we     <= 1'b0;
      o_ram_w_addr <= '0;
      o_ram_w_data <= ZeroWord;
      o_ram_r_addr <= '0;
`ifndef DATA_RAM_ARB_FIXED_PRIO_EN
      prefer_m1    <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      cmd_owner    <= cmd_owner_n;
      cmd_be       <= cmd_be_n;
      cmd_addr     <= cmd_addr_n;
      cmd_wdata    <= cmd_wdata_n;
      o_m0_gnt     <= gnt0_n;
      o_m1_gnt     <= gnt1_n;
      o_m0_rvalid  <= rvalid0_n;
      o_m1_rvalid  <= rvalid1_n;
      o_m0_rdata   <= rdata0_n;
      o_m1_rdata   <= rdata1_n;
      o_ram_we     <= we_n;
      o_ram_w_addr <= w_addr_n;
      o_ram_w_data <= w_data_n;
      o_ram_r_addr <= r_addr_n;
`ifndef DATA_RAM_ARB_FIXED_PRIO_EN
      prefer_m1    <= prefer_m1_n;
`endif
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed self-checking bench for data_ram_arbiter with a registered-read RAM model.
module tb_data_ram_arbiter;

  logic        i_Clk, i_reset;
  logic        i_m0_req, i_m0_we, i_m1_req, i_m1_we;
  logic [3:0]  i_m0_be, i_m1_be;
  logic [31:0] i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata;
  logic        o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_ram_we;
  logic [31:0] o_m0_rdata, o_m1_rdata, o_ram_w_addr, o_ram_w_data, o_ram_r_addr;
  logic [31:0] i_ram_r_data;

  data_ram_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
    .i_Clk(i_Clk), .i_reset(i_reset),
    .i_m0_req(i_m0_req), .i_m0_we(i_m0_we), .i_m0_be(i_m0_be),
    .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
    .i_m1_req(i_m1_req), .i_m1_we(i_m1_we), .i_m1_be(i_m1_be),
    .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
    .o_m0_gnt(o_m0_gnt), .o_m1_gnt(o_m1_gnt),
    .o_m0_rvalid(o_m0_rvalid), .o_m1_rvalid(o_m1_rvalid),
    .o_m0_rdata(o_m0_rdata), .o_m1_rdata(o_m1_rdata),
    .o_ram_we(o_ram_we), .o_ram_w_addr(o_ram_w_addr), .o_ram_w_data(o_ram_w_data),
    .o_ram_r_addr(o_ram_r_addr), .i_ram_r_data(i_ram_r_data)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  logic [31:0] mem [0:63];
  always @(posedge i_Clk) begin
    if (o_ram_we) mem[o_ram_w_addr[7:2]] <= o_ram_w_data;
    i_ram_r_data <= mem[o_ram_r_addr[7:2]];
  end

  int cyc = 0;
  always @(posedge i_Clk) cyc <= cyc + 1;

  int g0_n = 0, g1_n = 0, rv0_n = 0, rv1_n = 0, we_n = 0;
  int g0_cyc = 0, g1_cyc = 0, rv0_cyc = 0, rv1_cyc = 0, we_cyc = 0;
  logic [31:0] rv0_data = '0, rv1_data = '0, we_addr = '0, we_data = '0;
  always @(negedge i_Clk) begin
    if (o_m0_gnt)    begin g0_n++;  g0_cyc = cyc; end
    if (o_m1_gnt)    begin g1_n++;  g1_cyc = cyc; end
    if (o_m0_rvalid) begin rv0_n++; rv0_cyc = cyc; rv0_data = o_m0_rdata; end
    if (o_m1_rvalid) begin rv1_n++; rv1_cyc = cyc; rv1_data = o_m1_rdata; end
    if (o_ram_we)    begin we_n++;  we_cyc = cyc; we_addr = o_ram_w_addr; we_data = o_ram_w_data; end
  end

  int n_checks = 0, n_fails = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic drive(input int m, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] data);
    if (m == 0) begin
      i_m0_req = 1'b1; i_m0_we = we; i_m0_be = be; i_m0_addr = addr; i_m0_wdata = data;
    end else begin
      i_m1_req = 1'b1; i_m1_we = we; i_m1_be = be; i_m1_addr = addr; i_m1_wdata = data;
    end
  endtask

  // Request is held through the gnt cycle and dropped after the following edge
  task automatic issue(input int m, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] data,
                       output int req_cyc, output logic [31:0] raddr_seen);
    bit got;
    got = 1'b0;
    raddr_seen = '0;
    drive(m, we, be, addr, data);
    req_cyc = cyc;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge i_Clk);
      if ((m == 0) ? o_m0_gnt : o_m1_gnt) begin
        got = 1'b1;
        raddr_seen = o_ram_r_addr;
      end
    end
    @(posedge i_Clk); #1;
    if (m == 0) i_m0_req = 1'b0; else i_m1_req = 1'b0;
    check_value("gnt_seen", 32'(got), 32'd1);
  endtask

  // Both masters hold read requests until each has received its quota of grants
  task automatic contend(input int n0_in, input int n1_in, output logic [3:0] seq);
    int n0, n1;
    n0 = n0_in; n1 = n1_in; seq = '0;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 4'h0, 32'h4, 32'h0);
    for (int i = 0; i < 60 && (n0 > 0 || n1 > 0); i++) begin
      @(negedge i_Clk);
      if (o_m0_gnt) begin n0--; seq = {seq[2:0], 1'b0}; end
      if (o_m1_gnt) begin n1--; seq = {seq[2:0], 1'b1}; end
      @(posedge i_Clk); #1;
      i_m0_req = (n0 > 0);
      i_m1_req = (n1 > 0);
    end
    check_value("contend_done", 32'(n0 + n1), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rc, s_we, s_g0, s_g1, s_rv0, s_rv1;
    logic [31:0] ra;
    logic [3:0]  seq;

    i_reset = 1'b1;
    i_m0_req = 1'b0; i_m0_we = 1'b0; i_m0_be = '0; i_m0_addr = '0; i_m0_wdata = '0;
    i_m1_req = 1'b0; i_m1_we = 1'b0; i_m1_be = '0; i_m1_addr = '0; i_m1_wdata = '0;
    tick(2);
    @(negedge i_Clk);
    check_value("rst_gnt",    {30'd0, o_m0_gnt, o_m1_gnt}, 32'd0);
    check_value("rst_rvalid", {30'd0, o_m0_rvalid, o_m1_rvalid}, 32'd0);
    check_value("rst_we",     32'(o_ram_we), 32'd0);
    check_value("rst_addr",   o_ram_w_addr | o_ram_r_addr, 32'd0);
    check_value("rst_data",   o_ram_w_data | o_m0_rdata | o_m1_rdata, 32'd0);
    @(posedge i_Clk); #1;
    i_reset = 1'b0;

    // Full write then read-back
    s_we = we_n;
    issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rc, ra);
    tick(3);
    check_value("wr_gnt_lat", 32'(g0_cyc - rc), 32'd1);
    check_value("wr_we_cyc",  32'(we_cyc - g0_cyc), 32'd0);
    check_value("wr_we_cnt",  32'(we_n - s_we), 32'd1);
    check_value("wr_addr",    we_addr, 32'h10);
    check_value("wr_data",    we_data, 32'hDEADBEEF);

    s_rv1 = rv1_n;
    issue(0, 1'b0, 4'h0, 32'h10, 32'h0, rc, ra);
    tick(4);
    check_value("rd_raddr",   ra, 32'h10);
    check_value("rd_lat",     32'(rv0_cyc - g0_cyc), 32'd2);
    check_value("rd_data",    rv0_data, 32'hDEADBEEF);
    check_value("rd_no_m1rv", 32'(rv1_n - s_rv1), 32'd0);

    // Arbitration from a fresh pointer
    issue(0, 1'b1, 4'hF, 32'h0, 32'hA0A0A0A0, rc, ra);
    issue(1, 1'b1, 4'hF, 32'h4, 32'hB1B1B1B1, rc, ra);
    tick(2);
    i_reset = 1'b1;
    tick(1);
    i_reset = 1'b0;
    s_g0 = g0_n; s_g1 = g1_n; s_rv0 = rv0_n; s_rv1 = rv1_n;
    contend(2, 2, seq);
    tick(5);
`ifdef DATA_RAM_ARB_FIXED_PRIO_EN
    check_value("arb_order",  32'(seq), 32'h3);
`else
    check_value("arb_order",  32'(seq), 32'h5);
`endif
    check_value("arb_g0_cnt", 32'(g0_n - s_g0), 32'd2);
    check_value("arb_g1_cnt", 32'(g1_n - s_g1), 32'd2);
    check_value("arb_rv_cnt", 32'((rv0_n - s_rv0) + (rv1_n - s_rv1)), 32'd4);
    check_value("arb_m0_data", rv0_data, 32'hA0A0A0A0);
    check_value("arb_m1_data", rv1_data, 32'hB1B1B1B1);

    // Partial write via read-modify-write
    issue(1, 1'b1, 4'hF, 32'h20, 32'h11223344, rc, ra);
    tick(2);
    s_we = we_n;
    issue(1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, rc, ra);
    tick(5);
    check_value("rmw_we_cnt", 32'(we_n - s_we), 32'd1);
    check_value("rmw_we_cyc", 32'(we_cyc - g1_cyc), 32'd2);
    check_value("rmw_addr",   we_addr, 32'h20);
    check_value("rmw_data",   we_data, 32'h11BB33DD);
    check_value("rmw_mem",    mem[8], 32'h11BB33DD);

    // Zero-enable write leaves RAM untouched
    issue(0, 1'b1, 4'hF, 32'h8, 32'h12345678, rc, ra);
    tick(2);
    s_we = we_n; s_g0 = g0_n;
    issue(0, 1'b1, 4'h0, 32'h8, 32'hFFFFFFFF, rc, ra);
    tick(4);
    check_value("be0_gnt_cnt", 32'(g0_n - s_g0), 32'd1);
    check_value("be0_we_cnt",  32'(we_n - s_we), 32'd0);
    check_value("be0_mem",     mem[2], 32'h12345678);

    // Reset during RMW_MERGE drops the transaction
    s_we = we_n; s_rv0 = rv0_n; s_rv1 = rv1_n;
    drive(0, 1'b1, 4'b0011, 32'h20, 32'hCAFEF00D);
    @(negedge i_Clk);
    @(negedge i_Clk);
    check_value("rst_mid_gnt", 32'(o_m0_gnt), 32'd1);
    @(posedge i_Clk); #1;
    i_m0_req = 1'b0;
    i_reset  = 1'b1;
    @(posedge i_Clk); #1;
    i_reset  = 1'b0;
    @(negedge i_Clk);
    check_value("rst_mid_we_now", 32'(o_ram_we), 32'd0);
    tick(5);
    check_value("rst_mid_we_cnt", 32'(we_n - s_we), 32'd0);
    check_value("rst_mid_rv_cnt", 32'((rv0_n - s_rv0) + (rv1_n - s_rv1)), 32'd0);
    check_value("rst_mid_mem",    mem[8], 32'h11BB33DD);
    issue(0, 1'b0, 4'h0, 32'h20, 32'h0, rc, ra);
    tick(4);
    check_value("rst_mid_idle_lat", 32'(g0_cyc - rc), 32'd1);
    check_value("rst_mid_rd_data",  rv0_data, 32'h11BB33DD);

    // Unaligned read with req held through the gnt cycle
    s_g1 = g1_n; s_rv0 = rv0_n; s_rv1 = rv1_n;
    issue(1, 1'b0, 4'h0, 32'h13, 32'h0, rc, ra);
    tick(6);
    check_value("ua_raddr",   ra, 32'h10);
    check_value("ua_gnt_cnt", 32'(g1_n - s_g1), 32'd1);
    check_value("ua_rv_cnt",  32'(rv1_n - s_rv1), 32'd1);
    check_value("ua_m0_rv",   32'(rv0_n - s_rv0), 32'd0);
    check_value("ua_data",    rv1_data, 32'hDEADBEEF);
    @(negedge i_Clk);
    check_value("ua_rdata_hold", o_m1_rdata, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
